step_sequencer: RTL and testbench
=================================

STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 Parameter DEB_CYCLES, default 16, meaning: consecutive stable cycles required to accept a button press or release (range 2..65535).
REQ-002 CLK  in  1  system clock; the only clock; all state changes on its rising edge.
REQ-003 RSTb  in  1  reset, asynchronous and active-low.
REQ-004 EXECb  in  1  raw execute push-button, active-low, asynchronous to CLK.
REQ-005 INSTR  in  10  instruction word from the switches, sampled only at fetch.
REQ-006 LAST  in  1  decoder flag: the current TIME is the final timestep of the instruction in IR.
REQ-007 TIME  out  2  current timestep, 0..3.
REQ-008 IR  out  10  latched instruction register.
REQ-009 STEP_EN  out  1  one-cycle pulse per accepted press; datapath register write enable.
REQ-010 DONE  out  1  active-high; the instruction has completed.

Function
REQ-011 EXECb SHALL pass through a 2-flop synchronizer before any other use; the synchronizer adds 2 cycles of latency.
REQ-012 Button FSM states: WAIT_REL, REL, PRESS_CHK, HELD, REL_CHK.
REQ-013 WAIT_REL: go to REL once the synchronized level is high for DEB_CYCLES consecutive cycles.
REQ-014 REL: go to PRESS_CHK and clear the counter when the synchronized level is low.
REQ-015 PRESS_CHK: return to REL when the level goes high before DEB_CYCLES; otherwise, after DEB_CYCLES consecutive low cycles, go to HELD and generate exactly one accept event.
REQ-016 HELD: go to REL_CHK when the level is high; holding the button generates no further events.
REQ-017 REL_CHK: return to HELD on a low level; go to REL after DEB_CYCLES consecutive high cycles.
REQ-018 The debounce counter SHALL saturate, never wrap, and clear on every state change.
REQ-019 STEP_EN SHALL be high for exactly the cycle after the accept event; the debounce path is the only source of STEP_EN.
REQ-020 On STEP_EN with TIME==0: IR<=INSTR, DONE<=0, TIME<=1.
REQ-021 On STEP_EN with TIME in 1..3 and LAST==1: TIME<=0, DONE<=1.
REQ-022 On STEP_EN with TIME in 1..2 and LAST==0: TIME<=TIME+1, DONE unchanged.
REQ-023 On STEP_EN with TIME==3 and LAST==0: TIME<=0, DONE<=1 (forced wrap; no 2-bit overflow).
REQ-024 LAST SHALL be ignored when TIME==0 and whenever STEP_EN is low.
REQ-025 DONE SHALL hold 1 from completion until the next fetch (REQ-020) clears it.
REQ-026 TIME, IR and DONE SHALL change only on a STEP_EN cycle.
REQ-027 INSTR changes outside the fetch step SHALL NOT affect IR.

Reset
REQ-028 While RSTb==0: TIME=0, IR=0, DONE=0, STEP_EN=0, synchronizer flops=1, debounce counter=0, button FSM=WAIT_REL.
REQ-029 Reset mid-instruction SHALL abandon that instruction; the next accepted press is a fetch.
REQ-030 A button held low through reset release SHALL NOT produce an accept event until it has been released for DEB_CYCLES cycles.

Structure
REQ-031 Shared package proc_pkg SHALL hold the timestep_t (2-bit) typedef, the btn_state_t enum (REQ-012) and the DEB_CYCLES_DEFAULT constant.
REQ-032 Sub-module btn_debounce SHALL contain the synchronizer, the button FSM and the counter, and output a one-cycle accept pulse; step_sequencer SHALL contain the timestep and IR logic.

Verification (DEB_CYCLES=4)
REQ-033 Reset, EXECb=1 for 10 cycles, then a 10-cycle press with INSTR=10'h2A5 -> one STEP_EN pulse, IR=10'h2A5, TIME=1, DONE=0.
REQ-034 Three presses from TIME=1 with LAST=0,0,0 -> TIME goes 2, 3, then 0 with DONE=1 (forced wrap).
REQ-035 At TIME=1, press with LAST=1 -> TIME=0 and DONE=1; the next press with INSTR=10'h0F0 -> IR=10'h0F0 and DONE=0.
REQ-036 Bounce: low 3, high 1, low 3 cycles, then high -> no STEP_EN; a 200-cycle hold -> exactly one STEP_EN.
REQ-037 Assert RSTb=0 at TIME=2 while EXECb is held low; release reset while still held -> all outputs 0 and no STEP_EN until a release of 4 or more cycles followed by a fresh press.
REQ-038 INSTR toggled every cycle during TIME 1..3 -> IR is stable at the value fetched at TIME 0.

Source files
------------

// File: rtl/proc_pkg.sv
// proc_pkg: shared types and constants for the step sequencer and its button debouncer.
package proc_pkg;
  typedef logic [1:0] timestep_t;
  typedef enum logic [2:0] {WAIT_REL, REL, PRESS_CHK, HELD, REL_CHK} btn_state_t;
  localparam int DEB_CYCLES_DEFAULT = 16;
endpackage

// File: rtl/step_sequencer_if.sv
// step_sequencer_if: button/instruction inputs and timestep/IR outputs of the sequencer.
interface step_sequencer_if;
  import proc_pkg::*;
  logic       EXECb;
  logic [9:0] INSTR;
  logic       LAST;
  timestep_t  TIME;
  logic [9:0] IR;
  logic       STEP_EN;
  logic       DONE;
  modport master (output EXECb, INSTR, LAST, input TIME, IR, STEP_EN, DONE);
  modport slave  (input EXECb, INSTR, LAST, output TIME, IR, STEP_EN, DONE);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes the raw active-low button and emits one accept pulse per debounced press.
module btn_debounce import proc_pkg::*; #(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic CLK,
  input  logic RSTb,
  input  logic EXECb,
  output logic accept
);
  localparam logic [15:0] D1 = 16'(DEB_CYCLES - 1);
  localparam logic [15:0] D2 = 16'(DEB_CYCLES - 2);
  logic s1, s2, acc_n;
  logic [15:0] cnt, cnt_n;
  btn_state_t state, state_n;
  always_ff @(posedge CLK or negedge RSTb)
    if (!RSTb) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      state  <= WAIT_REL;
      cnt    <= '0;
      accept <= 1'b0;
    end else begin
      s1     <= EXECb;
      s2     <= s1;
      state  <= state_n;
      cnt    <= cnt_n;
      accept <= acc_n;
    end
  // The cycle that enters a check state counts as the first stable cycle, hence D2 there.
  always_comb begin
    state_n = state;
    acc_n   = 1'b0;
    case (state)
      WAIT_REL:  if (s2 && cnt == D1) state_n = REL;
      REL:       if (!s2) state_n = PRESS_CHK;
      PRESS_CHK: if (s2) state_n = REL;
                 else if (cnt == D2) begin
                   state_n = HELD;
                   acc_n   = 1'b1;
                 end
      HELD:      if (s2) state_n = REL_CHK;
      REL_CHK:   if (!s2) state_n = HELD;
                 else if (cnt == D2) state_n = REL;
      default:   state_n = WAIT_REL;
    endcase
    cnt_n = (state_n != state || (state == WAIT_REL && !s2)) ? '0 : (&cnt ? cnt : cnt + 16'd1);
  end
endmodule

// File: rtl/step_sequencer.sv
// step_sequencer: advances the instruction timestep and latches IR on each debounced button press.
module step_sequencer import proc_pkg::*; #(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input logic CLK,
  input logic RSTb,
  step_sequencer_if.slave bus
);
  logic       step_en, done_q;
  timestep_t  time_q;
  logic [9:0] ir_q;
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .CLK(CLK), .RSTb(RSTb), .EXECb(bus.EXECb), .accept(step_en)
  );
  // TIME==3 always completes, so the 2-bit counter never overflows into a bogus step.
  always_ff @(posedge CLK or negedge RSTb)
    if (!RSTb) begin
      time_q <= '0;
      ir_q   <= '0;
      done_q <= 1'b0;
    end else if (step_en) begin
      if (time_q == 2'd0) begin
        ir_q   <= bus.INSTR;
        done_q <= 1'b0;
        time_q <= 2'd1;
      end else if (bus.LAST || time_q == 2'd3) begin
        time_q <= 2'd0;
        done_q <= 1'b1;
      end else
        time_q <= time_q + 2'd1;
    end
  assign bus.STEP_EN = step_en;
  assign bus.TIME    = time_q;
  assign bus.IR      = ir_q;
  assign bus.DONE    = done_q;
endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: directed and random button presses checked every cycle against a behavioural model.
module tb_step_sequencer;
  import proc_pkg::*;
  localparam int D = 4;
  logic CLK = 1'b0, RSTb = 1'b1;
  int n_chk = 0, n_fail = 0, n_pulse = 0, p;
  bit on = 0, tog = 0, rnd = 0;
  step_sequencer_if bus();
  step_sequencer #(.DEB_CYCLES(D)) dut (.CLK(CLK), .RSTb(RSTb), .bus(bus));
  always #5 CLK = ~CLK;

  // Model: the button is a level seen two cycles late; a press counts once the level has been
  // low for D consecutive cycles after having been high for D consecutive cycles.
  logic [1:0] sq = 2'b11;
  int run = 0;
  logic prev = 1'b1, armed = 1'b0, step_m = 1'b0, done_m = 1'b0, lvl;
  timestep_t time_m = '0;
  logic [9:0] ir_m = '0;
  always @(posedge CLK or negedge RSTb)
    if (!RSTb) begin
      sq = 2'b11; run = 0; prev = 1'b1; armed = 1'b0;
      step_m = 1'b0; time_m = '0; ir_m = '0; done_m = 1'b0;
    end else begin
      if (step_m) begin
        if (time_m == 0) begin ir_m = bus.INSTR; done_m = 1'b0; time_m = 1; end
        else if (bus.LAST || time_m == 3) begin time_m = 0; done_m = 1'b1; end
        else time_m = time_m + 1;
      end
      lvl = sq[1];
      run = (lvl == prev) ? (run < 65535 ? run + 1 : run) : 1;
      prev = lvl;
      step_m = 1'b0;
      if (!armed && lvl && run == D) armed = 1'b1;
      else if (armed && !lvl && run == D) begin step_m = 1'b1; armed = 1'b0; end
      sq = {sq[0], bus.EXECb};
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) if (on) begin
    chk("step_en", 32'(bus.STEP_EN), 32'(step_m));
    chk("time", 32'(bus.TIME), 32'(time_m));
    chk("ir", 32'(bus.IR), 32'(ir_m));
    chk("done", 32'(bus.DONE), 32'(done_m));
    if (bus.STEP_EN === 1'b1) n_pulse++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
      if (tog || rnd) bus.INSTR = 10'($urandom);
      if (rnd) bus.LAST = 1'($urandom);
    end
  endtask

  task automatic press(input int lo, input int hi);
    bus.EXECb = 1'b0; tick(lo);
    bus.EXECb = 1'b1; tick(hi);
  endtask

  initial begin
    bus.EXECb = 1'b1; bus.INSTR = '0; bus.LAST = 1'b0;
    #1 RSTb = 1'b0; on = 1;
    tick(3);
    chk("rst_time", 32'(bus.TIME), 0);
    chk("rst_ir", 32'(bus.IR), 0);
    chk("rst_done", 32'(bus.DONE), 0);
    chk("rst_step", 32'(bus.STEP_EN), 0);
    RSTb = 1'b1; tick(10);
    bus.INSTR = 10'h2A5; p = n_pulse; press(10, 10);
    chk("fetch_pulses", 32'(n_pulse - p), 1);
    chk("fetch_ir", 32'(bus.IR), 32'h2A5);
    chk("fetch_time", 32'(bus.TIME), 1);
    chk("fetch_done", 32'(bus.DONE), 0);
    tog = 1;
    press(10, 10);
    chk("t2_time", 32'(bus.TIME), 2);
    chk("t2_done", 32'(bus.DONE), 0);
    press(10, 10);
    chk("t3_time", 32'(bus.TIME), 3);
    chk("t3_ir", 32'(bus.IR), 32'h2A5);
    press(10, 10);
    chk("wrap_time", 32'(bus.TIME), 0);
    chk("wrap_done", 32'(bus.DONE), 1);
    chk("wrap_ir", 32'(bus.IR), 32'h2A5);
    tog = 0;
    bus.INSTR = 10'h155; press(10, 10);
    chk("f2_ir", 32'(bus.IR), 32'h155);
    chk("f2_done", 32'(bus.DONE), 0);
    bus.LAST = 1'b1; press(10, 10);
    chk("last_time", 32'(bus.TIME), 0);
    chk("last_done", 32'(bus.DONE), 1);
    bus.LAST = 1'b0; bus.INSTR = 10'h0F0; press(10, 10);
    chk("f3_ir", 32'(bus.IR), 32'h0F0);
    chk("f3_done", 32'(bus.DONE), 0);
    chk("f3_time", 32'(bus.TIME), 1);
    p = n_pulse; press(3, 1); press(3, 10);
    chk("bounce_pulses", 32'(n_pulse - p), 0);
    chk("bounce_time", 32'(bus.TIME), 1);
    p = n_pulse; press(200, 10);
    chk("hold_pulses", 32'(n_pulse - p), 1);
    chk("hold_time", 32'(bus.TIME), 2);
    bus.EXECb = 1'b0; tick(3);
    RSTb = 1'b0; tick(3);
    chk("mid_rst_time", 32'(bus.TIME), 0);
    chk("mid_rst_ir", 32'(bus.IR), 0);
    chk("mid_rst_done", 32'(bus.DONE), 0);
    RSTb = 1'b1; p = n_pulse; tick(20);
    chk("held_rst_pulses", 32'(n_pulse - p), 0);
    bus.EXECb = 1'b1; tick(6);
    press(10, 10);
    chk("post_rst_pulses", 32'(n_pulse - p), 1);
    chk("post_rst_time", 32'(bus.TIME), 1);
    chk("post_rst_ir", 32'(bus.IR), 32'h0F0);
    rnd = 1;
    repeat (40) begin
      if ($urandom_range(0, 15) == 0) begin RSTb = 1'b0; tick(2); RSTb = 1'b1; end
      press($urandom_range(1, 12), $urandom_range(1, 12));
    end
    rnd = 0; tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
